// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the CPU data bus.
// Firmware pushes bytes into a small TX FIFO. A four-state FSM serialises
// them LSB first. Each bit lasts BAUDDIV+1 clocks, and the divider is latched
// per frame. Loads are combinational so the single-cycle core completes
// them in the same cycle.
module mmio_uart_tx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 15
) (
  input  logic        clk,
  input  logic        a_rstn,
  input  logic        sel,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [15:0]   baud_div;
  logic [15:0]   div_q, div_d;
  logic [15:0]   baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_d;
  logic          overflow;
  logic          full, empty, busy;
  logic          push_req, push, pop, ovf_clr, div_we;
  logic [7:0]    cnt_ext;
  logic          unused;

  // mem_re is accepted for bus symmetry only; loads have no side effects.
  assign unused   = ^{mem_re, addr[1:0], wdata[31:16]};

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign busy     = (state_q != IDLE);
  assign irq      = empty & ~busy;
  assign cnt_ext  = {{(7-AW){1'b0}}, count};

  assign push_req = sel & mem_we & (addr[3:2] == 2'd0);
  assign push     = push_req & ~full;   // full is the pre-edge value: a same-edge pop does not make room
  assign pop      = (state_q == IDLE) & ~empty;
  assign ovf_clr  = sel & mem_we & (addr[3:2] == 2'd1) & wdata[3];
  assign div_we   = sel & mem_we & (addr[3:2] == 2'd2);

  // FIFO storage: data only, so it needs no reset
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wdata[7:0];
  end

  // FIFO pointers, occupancy, sticky overflow and the BAUDDIV register
  always_ff @(posedge clk or negedge a_rstn) begin
    if (!a_rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      baud_div <= 16'(DEFAULT_DIV);
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (push_req && full) overflow <= 1'b1;
      else if (ovf_clr)     overflow <= 1'b0;
      if (div_we) baud_div <= wdata[15:0];
    end
  end

  // Transmit FSM state register; tx is a flop so it cannot glitch
  always_ff @(posedge clk or negedge a_rstn) begin
    if (!a_rstn) begin
      state_q    <= IDLE;
      div_q      <= '0;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx         <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx         <= tx_d;
    end
  end

  // Next-state logic. tx_d is decoded from the next state so the line
  // changes on the same edge the state does.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          shift_d    = fifo_mem[rd_ptr];
          div_d      = baud_div;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = START;
        end
      end
      START: begin
        if (baud_cnt_q == div_q) begin
          baud_cnt_d = '0;
          state_d    = DATA;
        end else baud_cnt_d = baud_cnt_q + 16'd1;
      end
      DATA: begin
        if (baud_cnt_q == div_q) begin
          baud_cnt_d = '0;
          shift_d    = shift_q >> 1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
          else bit_cnt_d = bit_cnt_q + 3'd1;
        end else baud_cnt_d = baud_cnt_q + 16'd1;
      end
      default: begin
        if (baud_cnt_q == div_q) begin
          baud_cnt_d = '0;
          state_d    = IDLE;
        end else baud_cnt_d = baud_cnt_q + 16'd1;
      end
    endcase
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Combinational load data; unselected or unmapped offsets read zero
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr[3:2])
        2'd1:    rdata = {16'h0, cnt_ext, 4'h0, overflow, busy, empty, full};
        2'd2:    rdata = {16'h0, baud_div};
        default: rdata = '0;
      endcase
    end
  end
endmodule
